// File: rtl/mean_ctrl_pkg.sv
// Shared definitions for the 3x3 mean window controller: FSM encoding,
// window tap constants and the tap-to-offset helpers.
package mean_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_RUN   = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  // Number of taps in the window and the fetch sequencing limits.
  localparam int unsigned WIN_TAPS   = 9;
  localparam logic [3:0]  K_LAST     = 4'd8;  // last read tap
  localparam logic [3:0]  FETCH_LAST = 4'd9;  // last FETCH cycle (capture of tap 8)

  // Row/column offset of tap k relative to the window's top-left corner,
  // packed two bits per tap with tap 0 in the least significant slot.
  localparam logic [17:0] WIN_ROW_OFF = {2'd2, 2'd2, 2'd2,
                                         2'd1, 2'd1, 2'd1,
                                         2'd0, 2'd0, 2'd0};
  localparam logic [17:0] WIN_COL_OFF = {2'd2, 2'd1, 2'd0,
                                         2'd2, 2'd1, 2'd0,
                                         2'd2, 2'd1, 2'd0};

  // Row offset (0..2) of tap k; taps beyond the window map to 0.
  function automatic logic [1:0] row_off(input logic [3:0] k);
    if (k <= K_LAST) begin
      return WIN_ROW_OFF[{k, 1'b0} +: 2];
    end else begin
      return 2'd0;
    end
  endfunction

  // Column offset (0..2) of tap k; taps beyond the window map to 0.
  function automatic logic [1:0] col_off(input logic [3:0] k);
    if (k <= K_LAST) begin
      return WIN_COL_OFF[{k, 1'b0} +: 2];
    end else begin
      return 2'd0;
    end
  endfunction

endpackage

// File: rtl/mean_window_ctrl_win_addr_gen.sv
// Window address generator: maps a window centre (row, col) and a tap
// index (0..8, row-major) to the linear address of that source pixel.
module win_addr_gen
  import mean_ctrl_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic [ADDR_WIDTH-1:0] row,
  input  logic [ADDR_WIDTH-1:0] col,
  input  logic [3:0]            tap,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ADDR_WIDTH-1:0] IMG_W_A = ADDR_WIDTH'(IMG_W);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] win_row_s;
  logic [ADDR_WIDTH-1:0] win_col_s;

  // Centre minus one plus tap offset gives the pixel coordinate; raster it.
  always_comb begin
    win_row_s = row + {{(ADDR_WIDTH-2){1'b0}}, row_off(tap)} - ONE_A;
    win_col_s = col + {{(ADDR_WIDTH-2){1'b0}}, col_off(tap)} - ONE_A;
    addr      = win_row_s * IMG_W_A + win_col_s;
  end

endmodule

// File: rtl/mean_window_ctrl.sv
// Mean window controller: walks every interior pixel of an image, fetches
// its 3x3 neighbourhood from the source RAM, hands the window to an external
// mean engine, and writes the engine result to the result RAM.
module mean_window_ctrl
  import mean_ctrl_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 32
) (
  input  logic                  clk_i_ctrl,
  input  logic                  rst_i_ctrl,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] win_o_0,
  output logic [DATA_WIDTH-1:0] win_o_1,
  output logic [DATA_WIDTH-1:0] win_o_2,
  output logic [DATA_WIDTH-1:0] win_o_3,
  output logic [DATA_WIDTH-1:0] win_o_4,
  output logic [DATA_WIDTH-1:0] win_o_5,
  output logic [DATA_WIDTH-1:0] win_o_6,
  output logic [DATA_WIDTH-1:0] win_o_7,
  output logic [DATA_WIDTH-1:0] win_o_8,
  output logic                  en_o_mean,
  input  logic [DATA_WIDTH-1:0] mean_data_i,
  input  logic                  mean_done_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [ADDR_WIDTH-1:0] pix_cnt_o
);

  // Elaboration-time sanity checks on the geometry.
  if (IMG_W < 3 || IMG_H < 3) begin : g_bad_dims
    $error("mean_window_ctrl: IMG_W and IMG_H must be at least 3");
  end
  if ((longint'(IMG_W) * longint'(IMG_H)) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr
    $error("mean_window_ctrl: IMG_W*IMG_H does not fit in ADDR_WIDTH");
  end

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_W - 2);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(IMG_H - 2);
  localparam logic [ADDR_WIDTH-1:0] OUT_W_A  = ADDR_WIDTH'(IMG_W - 2);

  state_t state_r;
  state_t state_nxt_s;

  logic [ADDR_WIDTH-1:0] row_r;
  logic [ADDR_WIDTH-1:0] col_r;
  logic [ADDR_WIDTH-1:0] row_nxt_s;
  logic [ADDR_WIDTH-1:0] col_nxt_s;
  logic [ADDR_WIDTH-1:0] gen_addr_s;
  logic [3:0]            tap_sel_s;
  logic [3:0]            fetch_cnt_r;
  logic [TMO_W-1:0]      tmo_cnt_r;
  logic                  last_col_s;
  logic                  last_row_s;
  logic                  tmo_hit_s;

  logic [DATA_WIDTH-1:0] win_r [0:WIN_TAPS-1];
  logic [DATA_WIDTH-1:0] result_r;

  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  logic                  rd_en_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic                  en_mean_r;
  logic                  wr_en_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic [ADDR_WIDTH-1:0] pix_cnt_r;

  // Read address of the tap that will be presented next cycle.
  win_addr_gen #(
    .IMG_W      (IMG_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_win_addr_gen (
    .row  (row_nxt_s),
    .col  (col_nxt_s),
    .tap  (tap_sel_s),
    .addr (gen_addr_s)
  );

  // Scan position flags and the centre/tap that the next read will use.
  always_comb begin
    last_col_s = (col_r >= COL_LAST);
    last_row_s = (row_r >= ROW_LAST);
    tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
    row_nxt_s  = row_r;
    col_nxt_s  = col_r;
    tap_sel_s  = fetch_cnt_r + 4'd1;
    case (state_r)
      ST_IDLE: begin
        row_nxt_s = ONE_A;
        col_nxt_s = ONE_A;
        tap_sel_s = 4'd0;
      end
      ST_NEXT: begin
        tap_sel_s = 4'd0;
        if (!last_col_s) begin
          col_nxt_s = col_r + ONE_A;
        end else if (!last_row_s) begin
          row_nxt_s = row_r + ONE_A;
          col_nxt_s = ONE_A;
        end else begin
          row_nxt_s = row_r;
          col_nxt_s = col_r;
        end
      end
      default: begin
        row_nxt_s = row_r;
        col_nxt_s = col_r;
      end
    endcase
  end

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (fetch_cnt_r == FETCH_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_RUN: begin
        if (mean_done_i) begin
          state_nxt_s = ST_WRITE;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WRITE: state_nxt_s = ST_NEXT;
      ST_NEXT: begin
        if (last_col_s && last_row_s) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i_ctrl or negedge rst_i_ctrl) begin
    if (!rst_i_ctrl) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered outputs; every output changes the cycle after
  // the state that commands it, so the write pulse trails WRITE by one cycle.
  always_ff @(posedge clk_i_ctrl or negedge rst_i_ctrl) begin
    if (!rst_i_ctrl) begin
      row_r       <= '0;
      col_r       <= '0;
      fetch_cnt_r <= 4'd0;
      tmo_cnt_r   <= '0;
      result_r    <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
      en_mean_r   <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      pix_cnt_r   <= '0;
      for (int i = 0; i < WIN_TAPS; i++) begin
        win_r[i] <= '0;
      end
    end else begin
      done_r  <= 1'b0;
      wr_en_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            row_r       <= row_nxt_s;
            col_r       <= col_nxt_s;
            pix_cnt_r   <= '0;
            err_r       <= 1'b0;
            busy_r      <= 1'b1;
            fetch_cnt_r <= 4'd0;
            rd_en_r     <= 1'b1;
            rd_addr_r   <= gen_addr_s;
          end
        end
        ST_FETCH: begin
          fetch_cnt_r <= fetch_cnt_r + 4'd1;
          // Read k returns data one cycle later, so FETCH cycle k+1 captures tap k.
          for (int i = 0; i < WIN_TAPS; i++) begin
            if (fetch_cnt_r == 4'(i + 1)) begin
              win_r[i] <= rd_data_i;
            end
          end
          if (fetch_cnt_r < K_LAST) begin
            rd_en_r   <= 1'b1;
            rd_addr_r <= gen_addr_s;
          end else begin
            rd_en_r   <= 1'b0;
          end
          if (fetch_cnt_r == FETCH_LAST) begin
            en_mean_r <= 1'b1;
            tmo_cnt_r <= '0;
          end
        end
        ST_RUN: begin
          tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
          if (mean_done_i) begin
            result_r  <= mean_data_i;
            en_mean_r <= 1'b0;
          end else if (tmo_hit_s) begin
            en_mean_r <= 1'b0;
          end
        end
        ST_WRITE: begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= (row_r - ONE_A) * OUT_W_A + (col_r - ONE_A);
          wr_data_r <= result_r;
          pix_cnt_r <= pix_cnt_r + ONE_A;
        end
        ST_NEXT: begin
          row_r <= row_nxt_s;
          col_r <= col_nxt_s;
          if (!(last_col_s && last_row_s)) begin
            fetch_cnt_r <= 4'd0;
            rd_en_r     <= 1'b1;
            rd_addr_r   <= gen_addr_s;
          end
        end
        ST_FIN: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        ST_ERR: begin
          err_r  <= 1'b1;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: begin
          busy_r    <= 1'b0;
          rd_en_r   <= 1'b0;
          en_mean_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign err_o     = err_r;
  assign rd_en_o   = rd_en_r;
  assign rd_addr_o = rd_addr_r;
  assign en_o_mean = en_mean_r;
  assign wr_en_o   = wr_en_r;
  assign wr_addr_o = wr_addr_r;
  assign wr_data_o = wr_data_r;
  assign pix_cnt_o = pix_cnt_r;
  assign win_o_0   = win_r[0];
  assign win_o_1   = win_r[1];
  assign win_o_2   = win_r[2];
  assign win_o_3   = win_r[3];
  assign win_o_4   = win_r[4];
  assign win_o_5   = win_r[5];
  assign win_o_6   = win_r[6];
  assign win_o_7   = win_r[7];
  assign win_o_8   = win_r[8];

endmodule

// File: tb/tb_mean_window_ctrl.sv
// Bench for mean_window_ctrl: a 4x4 instance (flat image, timeout, held
// start, mid-frame reset, spurious done) and a 5x5 instance (address image).
// Expected writes are queued before each frame; monitors pop and compare.
module tb_mean_window_ctrl;

  localparam int ENG_LAT = 6;
  localparam int EXP_LAT = 10 + ENG_LAT + 2;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic clk;
  logic rst_n;

  // 4x4 instance signals
  logic        start4, busy4, done4, err4, rd_en4, en4, mean_done4, wr_en4;
  logic [11:0] rd_addr4, wr_addr4, pix_cnt4;
  logic [7:0]  rd_data4, mean_data4, wr_data4, eng_data4;
  logic [7:0]  win4 [0:8];
  logic [7:0]  mem4 [0:15];
  logic        eng_done4 = 1'b0;
  int          ecnt4 = 0;
  bit          never4 = 1'b0;
  bit          spur_mode4 = 1'b0;
  exp_t        q4[$];

  // 5x5 instance signals
  logic        start5, busy5, done5, err5, rd_en5, en5, mean_done5, wr_en5;
  logic [11:0] rd_addr5, wr_addr5, pix_cnt5;
  logic [7:0]  rd_data5, mean_data5, wr_data5, eng_data5;
  logic [7:0]  win5 [0:8];
  logic [7:0]  mem5 [0:31];
  logic        eng_done5 = 1'b0;
  int          ecnt5 = 0;
  exp_t        q5[$];
  logic [11:0] rdlog5[$];

  int n_vec  = 0;
  int n_miss = 0;

  // Hand-computed 5x5 results: first read order and per-window means.
  int rd_order5 [0:8] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int exp_mean5 [0:8] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

  mean_window_ctrl #(.IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk_i_ctrl (clk),       .rst_i_ctrl (rst_n),      .start_i     (start4),
    .busy_o     (busy4),     .done_o     (done4),      .err_o       (err4),
    .rd_en_o    (rd_en4),    .rd_addr_o  (rd_addr4),   .rd_data_i   (rd_data4),
    .win_o_0    (win4[0]),   .win_o_1    (win4[1]),    .win_o_2     (win4[2]),
    .win_o_3    (win4[3]),   .win_o_4    (win4[4]),    .win_o_5     (win4[5]),
    .win_o_6    (win4[6]),   .win_o_7    (win4[7]),    .win_o_8     (win4[8]),
    .en_o_mean  (en4),       .mean_data_i(mean_data4), .mean_done_i (mean_done4),
    .wr_en_o    (wr_en4),    .wr_addr_o  (wr_addr4),   .wr_data_o   (wr_data4),
    .pix_cnt_o  (pix_cnt4)
  );

  mean_window_ctrl #(.IMG_W(5), .IMG_H(5)) u_dut5 (
    .clk_i_ctrl (clk),       .rst_i_ctrl (rst_n),      .start_i     (start5),
    .busy_o     (busy5),     .done_o     (done5),      .err_o       (err5),
    .rd_en_o    (rd_en5),    .rd_addr_o  (rd_addr5),   .rd_data_i   (rd_data5),
    .win_o_0    (win5[0]),   .win_o_1    (win5[1]),    .win_o_2     (win5[2]),
    .win_o_3    (win5[3]),   .win_o_4    (win5[4]),    .win_o_5     (win5[5]),
    .win_o_6    (win5[6]),   .win_o_7    (win5[7]),    .win_o_8     (win5[8]),
    .en_o_mean  (en5),       .mean_data_i(mean_data5), .mean_done_i (mean_done5),
    .wr_en_o    (wr_en5),    .wr_addr_o  (wr_addr5),   .wr_data_o   (wr_data5),
    .pix_cnt_o  (pix_cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spurious done (with a poisoned result) is injected only while reading.
  assign mean_done4 = eng_done4 | (spur_mode4 & rd_en4);
  assign mean_data4 = (spur_mode4 & rd_en4) ? 8'hEE : eng_data4;
  assign mean_done5 = eng_done5;
  assign mean_data5 = eng_data5;

  // Source RAMs: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en4) rd_data4 <= mem4[rd_addr4[3:0]];
    if (rd_en5) rd_data5 <= mem5[rd_addr5[4:0]];
  end

  // Mean engine models: result ENG_LAT cycles after enable rises.
  always @(posedge clk) begin : eng_models
    int s4, s5;
    s4 = 0;
    s5 = 0;
    for (int k = 0; k < 9; k++) begin
      s4 = s4 + int'(win4[k]);
      s5 = s5 + int'(win5[k]);
    end
    if (!en4) begin
      ecnt4 <= 0;
      eng_done4 <= 1'b0;
    end else begin
      ecnt4 <= ecnt4 + 1;
      eng_done4 <= (!never4 && ecnt4 == ENG_LAT - 1);
      eng_data4 <= 8'(s4 / 9);
    end
    if (!en5) begin
      ecnt5 <= 0;
      eng_done5 <= 1'b0;
    end else begin
      ecnt5 <= ecnt5 + 1;
      eng_done5 <= (ecnt5 == ENG_LAT - 1);
      eng_data5 <= 8'(s5 / 9);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the 4x4 instance, including FETCH-to-write latency.
  int   cyc4 = 0, fetch_t4 = 0;
  logic rd_prev4 = 1'b0;
  exp_t e4;
  always @(negedge clk) begin
    cyc4 = cyc4 + 1;
    if (rd_en4 && !rd_prev4) fetch_t4 = cyc4;
    rd_prev4 = rd_en4;
    if (wr_en4) begin
      if (q4.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL dut4 unexpected write: addr %0d data %0d, expected none", wr_addr4, wr_data4);
      end else begin
        e4 = q4.pop_front();
        check("dut4 wr_addr", 32'(wr_addr4), 32'(e4.addr));
        check("dut4 wr_data", 32'(wr_data4), 32'(e4.data));
        check("dut4 latency", 32'(cyc4 - fetch_t4), 32'(EXP_LAT));
      end
    end
  end

  // Scoreboard monitor for the 5x5 instance plus read-order log.
  int   cyc5 = 0, fetch_t5 = 0;
  logic rd_prev5 = 1'b0;
  exp_t e5;
  always @(negedge clk) begin
    cyc5 = cyc5 + 1;
    if (rd_en5 && !rd_prev5) fetch_t5 = cyc5;
    rd_prev5 = rd_en5;
    if (rd_en5 && rdlog5.size() < 9) rdlog5.push_back(rd_addr5);
    if (wr_en5) begin
      if (q5.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL dut5 unexpected write: addr %0d data %0d, expected none", wr_addr5, wr_data5);
      end else begin
        e5 = q5.pop_front();
        check("dut5 wr_addr", 32'(wr_addr5), 32'(e5.addr));
        check("dut5 wr_data", 32'(wr_data5), 32'(e5.data));
        check("dut5 latency", 32'(cyc5 - fetch_t5), 32'(EXP_LAT));
      end
    end
  end

  task automatic check_zero4(input string tag);
    check({tag, " ctl bits"}, 32'({busy4, done4, err4, rd_en4, en4, wr_en4}), 32'd0);
    check({tag, " pix_cnt"}, 32'(pix_cnt4), 32'd0);
    check({tag, " rd_addr"}, 32'(rd_addr4), 32'd0);
    check({tag, " wr_addr"}, 32'(wr_addr4), 32'd0);
    check({tag, " wr_data"}, 32'(wr_data4), 32'd0);
    for (int k = 0; k < 9; k++) check({tag, " win"}, 32'(win4[k]), 32'd0);
  endtask

  task automatic pulse_start4();
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_done4();
    for (int i = 0; i < 3000; i++) begin
      if (done4) break;
      @(negedge clk);
    end
    check("dut4 done seen", 32'(done4), 32'd1);
  endtask

  task automatic wait_en4();
    for (int i = 0; i < 500; i++) begin
      if (en4) break;
      @(negedge clk);
    end
    check("dut4 en_o_mean seen", 32'(en4), 32'd1);
  endtask

  task automatic push4(input int n, input logic [7:0] d);
    for (int a = 0; a < n; a++) q4.push_back('{addr: 12'(a), data: d});
  endtask

  initial begin
    int n;
    int rises;
    logic prev;
    rst_n = 1'b0;
    start4 = 1'b0;
    start5 = 1'b0;
    for (int i = 0; i < 16; i++) mem4[i] = 8'd90;
    for (int i = 0; i < 32; i++) mem5[i] = 8'(i);
    repeat (3) @(negedge clk);
    check_zero4("reset");
    check("dut5 reset ctl bits", 32'({busy5, done5, err5, rd_en5, en5, wr_en5}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Flat 4x4 image of 90: four writes at 0..3, one-cycle done.
    push4(4, 8'd90);
    pulse_start4();
    check("t1 busy during frame", 32'(busy4), 32'd1);
    wait_done4();
    check("t1 err", 32'(err4), 32'd0);
    check("t1 busy after", 32'(busy4), 32'd0);
    check("t1 pix_cnt", 32'(pix_cnt4), 32'd4);
    check("t1 queue drained", 32'(q4.size()), 32'd0);
    @(negedge clk);
    check("t1 done width", 32'(done4), 32'd0);

    // Engine never answers: 32 RUN cycles, then error and done, no writes.
    never4 = 1'b1;
    pulse_start4();
    wait_en4();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!en4) break;
      n++;
      @(negedge clk);
    end
    check("t2 run cycles", 32'(n), 32'd32);
    wait_done4();
    check("t2 err", 32'(err4), 32'd1);
    check("t2 busy", 32'(busy4), 32'd0);
    check("t2 pix_cnt", 32'(pix_cnt4), 32'd0);
    @(negedge clk);
    check("t2 done width", 32'(done4), 32'd0);
    check("t2 err sticky", 32'(err4), 32'd1);
    never4 = 1'b0;

    // Start held high: exactly one frame, err cleared on start.
    push4(4, 8'd90);
    start4 = 1'b1;
    @(negedge clk);
    check("t3 err cleared", 32'(err4), 32'd0);
    check("t3 busy", 32'(busy4), 32'd1);
    wait_done4();
    start4 = 1'b0;
    check("t3 pix_cnt", 32'(pix_cnt4), 32'd4);
    repeat (20) @(negedge clk);
    check("t3 no restart busy", 32'(busy4), 32'd0);
    check("t3 no restart pix", 32'(pix_cnt4), 32'd4);
    check("t3 queue drained", 32'(q4.size()), 32'd0);

    // Reset during the third RUN: two writes only, outputs cleared at once.
    push4(2, 8'd90);
    pulse_start4();
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 2000 && rises < 3; i++) begin
      if (en4 && !prev) rises++;
      prev = en4;
      if (rises < 3) @(negedge clk);
    end
    check("t4 third run reached", 32'(rises), 32'd3);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero4("t4 async reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t4 idle busy", 32'(busy4), 32'd0);
    check("t4 pix_cnt", 32'(pix_cnt4), 32'd0);
    check("t4 queue drained", 32'(q4.size()), 32'd0);

    // Spurious done during FETCH must not change count or data.
    spur_mode4 = 1'b1;
    push4(4, 8'd90);
    pulse_start4();
    wait_done4();
    check("t5 pix_cnt", 32'(pix_cnt4), 32'd4);
    check("t5 err", 32'(err4), 32'd0);
    check("t5 queue drained", 32'(q4.size()), 32'd0);
    spur_mode4 = 1'b0;

    // 5x5 address image: read order, window contents, nine writes.
    for (int a = 0; a < 9; a++) q5.push_back('{addr: 12'(a), data: 8'(exp_mean5[a])});
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (en5) break;
      @(negedge clk);
    end
    check("t6 en_o_mean seen", 32'(en5), 32'd1);
    for (int k = 0; k < 9; k++) check("t6 first window", 32'(win5[k]), 32'(rd_order5[k]));
    for (int i = 0; i < 3000; i++) begin
      if (done5) break;
      @(negedge clk);
    end
    check("t6 done seen", 32'(done5), 32'd1);
    check("t6 err", 32'(err5), 32'd0);
    check("t6 pix_cnt", 32'(pix_cnt5), 32'd9);
    check("t6 queue drained", 32'(q5.size()), 32'd0);
    check("t6 read log size", 32'(rdlog5.size()), 32'd9);
    for (int k = 0; k < rdlog5.size(); k++) check("t6 read order", 32'(rdlog5[k]), 32'(rd_order5[k]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global time limit in case a bounded wait is somehow bypassed.
  initial begin
    #2000000;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mean_window_ctrl.md
MEAN_WINDOW_CTRL -- requirements
Module: mean_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8, image width in pixels (min 3).
REQ-002 SHALL have parameter IMG_H, default 8, image height in pixels (min 3).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 12, pixel memory address width.
REQ-005 SHALL have parameter TIMEOUT, default 32, max cycles to wait for engine done.
REQ-006 SHALL have port clk_i_ctrl, in, 1, single clock, all logic on rising edge.
REQ-007 SHALL have port rst_i_ctrl, in, 1, asynchronous active-low reset.
REQ-008 SHALL have ports start_i (in, 1), busy_o (out, 1), done_o (out, 1) and err_o (out, 1), for frame control and status.
REQ-009 SHALL have ports rd_en_o (out, 1), rd_addr_o (out, ADDR_WIDTH) and rd_data_i (in, DATA_WIDTH), for the source pixel RAM; read data is valid 1 cycle after rd_en_o.
REQ-010 SHALL have ports win_o_0..win_o_8 (out, DATA_WIDTH each), the 3x3 window in row-major order.
REQ-011 SHALL have ports en_o_mean (out, 1), mean_data_i (in, DATA_WIDTH) and mean_done_i (in, 1), for the mean engine handshake.
REQ-012 SHALL have ports wr_en_o (out, 1), wr_addr_o (out, ADDR_WIDTH) and wr_data_o (out, DATA_WIDTH), for the result RAM.
REQ-013 SHALL have port pix_cnt_o, out, ADDR_WIDTH, count of results written in the current frame.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, RUN, WRITE, NEXT, FIN, ERR.
REQ-015 IDLE: when start_i=1, SHALL set centre (r,c)=(1,1), clear pix_cnt_o and err_o, assert busy_o and go to FETCH; start_i is ignored in every other state.
REQ-016 FETCH: SHALL issue 9 reads on consecutive cycles, k=0..8, at rd_addr_o=(r-1+k/3)*IMG_W+(c-1+k%3).
REQ-017 FETCH: SHALL capture rd_data_i into win_o_k one cycle after read k; FETCH lasts exactly 10 cycles, then SHALL go to RUN.
REQ-018 RUN: SHALL hold en_o_mean=1 and win_o_* stable until mean_done_i=1 is sampled, then latch mean_data_i and go to WRITE.
REQ-019 RUN: if mean_done_i is not seen within TIMEOUT cycles, SHALL go to ERR.
REQ-020 en_o_mean SHALL be 0 in every state except RUN, giving the engine at least 1 idle cycle between windows.
REQ-021 WRITE: SHALL pulse wr_en_o for 1 cycle with wr_addr_o=(r-1)*(IMG_W-2)+(c-1) and wr_data_o=latched result, and SHALL increment pix_cnt_o.
REQ-022 NEXT: if c<IMG_W-2, SHALL set c=c+1; else if r<IMG_H-2, SHALL set c=1, r=r+1; else SHALL go to FIN. Otherwise it SHALL go to FETCH.
REQ-023 Border pixels SHALL be neither processed nor written; one frame yields (IMG_W-2)*(IMG_H-2) writes.
REQ-024 FIN: SHALL pulse done_o for 1 cycle, deassert busy_o and return to IDLE.
REQ-025 ERR: SHALL set err_o=1 (sticky until next start), pulse done_o for 1 cycle, deassert busy_o, go to IDLE, and perform no further writes.
REQ-026 A mean_done_i seen outside RUN SHALL be ignored.
REQ-027 Address arithmetic SHALL use ADDR_WIDTH-bit unsigned values; IMG_W*IMG_H SHALL fit in ADDR_WIDTH (elaboration check).
REQ-028 Per-window latency from FETCH entry to wr_en_o SHALL be 10 + engine latency + 2 cycles.

Reset
REQ-029 On rst_i_ctrl=0 (asynchronous), SHALL force state=IDLE and r=c=0.
REQ-030 On rst_i_ctrl=0, SHALL force all outputs to 0, including busy_o, done_o, err_o, rd_en_o, en_o_mean, wr_en_o, win_o_*, pix_cnt_o and addresses.
REQ-031 Reset mid-frame SHALL abandon the frame with no partial write after reset release.

Structure
REQ-032 FSM state encoding and the window offset constants SHALL live in shared package mean_ctrl_pkg.
REQ-033 SHALL contain one natural sub-module, win_addr_gen: it maps (r,c,k) to the read address.
REQ-034 The mean engine SHALL be external and instantiated beside this block at top level, not inside it.

Verification
REQ-035 4x4 image, all pixels 90, engine model done after 6 cycles: SHALL produce 4 writes at addresses 0..3, each data 90, then a 1-cycle done_o pulse with err_o=0.
REQ-036 5x5 image with pixel value = address: the first window read order SHALL be 0,1,2,5,6,7,10,11,12, and the 9th write SHALL be at address 8.
REQ-037 Engine model never asserts done: after TIMEOUT=32 cycles in RUN, SHALL give err_o=1, done_o pulse, and no wr_en_o ever.
REQ-038 start_i held high throughout the frame: exactly one frame SHALL run, and a new frame SHALL start only from IDLE.
REQ-039 rst_i_ctrl pulled low during the 3rd RUN: all outputs SHALL be 0 immediately, and after release the block SHALL stay in IDLE with pix_cnt_o=0.
REQ-040 Spurious mean_done_i during FETCH SHALL be ignored: the write count and data SHALL be unchanged versus the clean run.
